// File: rtl/iter_shift_unit_if.sv
// Handshake/data bundle for iter_shift_unit.
// SHIFT_ABORT_EN adds the abort request line.
interface iter_shift_unit_if #(
  parameter int N = 32
) ();
  localparam int SHW = $clog2(N);

  logic           start;
  logic [2:0]     mode;
  logic [N-1:0]   din;
  logic [SHW-1:0] shamt;
  logic           busy;
  logic           done;
  logic [N-1:0]   dout;
  logic           err;
`ifdef SHIFT_ABORT_EN
  logic           abort;

  modport master (output start, mode, din, shamt, abort,
                  input  busy, done, dout, err);
  modport slave  (input  start, mode, din, shamt, abort,
                  output busy, done, dout, err);
`else
  modport master (output start, mode, din, shamt,
                  input  busy, done, dout, err);
  modport slave  (input  start, mode, din, shamt,
                  output busy, done, dout, err);
`endif
endinterface

// File: rtl/iter_shift_unit.sv
// Multi-cycle shifter: up to STEP positions per cycle, start/busy/done handshake.
// Optional SHIFT_ABORT_EN: abort in SHIFT ends the operation early with err.
module iter_shift_unit #(
  parameter int N    = 32,
  parameter int STEP = 1
) (
  input  logic           clk,
  input  logic           resetn,
  iter_shift_unit_if.slave bus
);
  localparam int SHW = $clog2(N);
  localparam logic [SHW:0] STEP_W = (SHW+1)'(STEP);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
  typedef enum logic [2:0] {
    M_LOAD = 3'b000, M_SLL = 3'b001, M_SRL = 3'b010, M_SRA = 3'b011,
    M_ROL  = 3'b100, M_ROR = 3'b101, M_RSV0 = 3'b110, M_RSV1 = 3'b111
  } mode_t;

  state_t         state, state_n;
  mode_t          mode_q, mode_n, mode_in;
  logic [N-1:0]   dout_q, dout_n, shifted;
  logic [SHW-1:0] cnt_q, cnt_n, k;
  logic [2*N-1:0] dbl_l, dbl_r;
  logic           done_q, done_n, err_q, err_n;
  logic           in_shift_mode;

  // Step size for this cycle: the remainder on the last partial step.
  always_comb k = ({1'b0, cnt_q} < STEP_W) ? cnt_q : STEP_W[SHW-1:0];

  always_comb begin
    dbl_l   = {dout_q, dout_q} << k;
    dbl_r   = {dout_q, dout_q} >> k;
    shifted = dout_q;
    case (mode_q)
      M_SLL:   shifted = dout_q << k;
      M_SRL:   shifted = dout_q >> k;
      M_SRA:   shifted = $signed(dout_q) >>> k;
      M_ROL:   shifted = dbl_l[2*N-1:N];
      M_ROR:   shifted = dbl_r[N-1:0];
      default: shifted = dout_q;
    endcase
  end

  always_comb begin
    mode_in       = mode_t'(bus.mode);
    in_shift_mode = (mode_in == M_SLL) || (mode_in == M_SRL) || (mode_in == M_SRA) ||
                    (mode_in == M_ROL) || (mode_in == M_ROR);
  end

  always_comb begin
    state_n = state;
    mode_n  = mode_q;
    dout_n  = dout_q;
    cnt_n   = cnt_q;
    err_n   = 1'b0;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          mode_n = mode_in;
          dout_n = bus.din;
          cnt_n  = in_shift_mode ? bus.shamt : '0;
          if (cnt_n != '0) begin
            state_n = S_SHIFT;
          end else begin
            state_n = S_DONE;
            err_n   = (mode_in == M_RSV0) || (mode_in == M_RSV1);
          end
        end else if (state == S_DONE) begin
          state_n = S_IDLE;
        end
      end
      S_SHIFT: begin
        dout_n = shifted;
        cnt_n  = cnt_q - k;
        if (cnt_n == '0) state_n = S_DONE;
`ifdef SHIFT_ABORT_EN
        // The step on the abort edge still lands; only the remainder is dropped.
        if (bus.abort) begin
          state_n = S_DONE;
          cnt_n   = '0;
          err_n   = 1'b1;
        end
`endif
      end
      default: state_n = S_IDLE;
    endcase
    done_n = (state_n == S_DONE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= S_IDLE;
      mode_q <= M_LOAD;
      dout_q <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_n;
      mode_q <= mode_n;
      dout_q <= dout_n;
      cnt_q  <= cnt_n;
      done_q <= done_n;
      err_q  <= err_n;
    end
  end

  assign bus.busy = (state == S_SHIFT);
  assign bus.done = done_q;
  assign bus.err  = err_q;
  assign bus.dout = dout_q;
endmodule

// File: tb/tb_iter_shift_unit.sv
// Directed bench for iter_shift_unit: STEP=1 vector table plus STEP=4,
// back-to-back, async reset and (with SHIFT_ABORT_EN) abort sequences.
module tb_iter_shift_unit;
  logic clk;
  logic resetn;
  int   total;
  int   passed;

  iter_shift_unit_if #(.N(32)) bus1 ();
  iter_shift_unit_if #(.N(32)) bus4 ();

  iter_shift_unit #(.N(32), .STEP(1)) dut1 (.clk(clk), .resetn(resetn), .bus(bus1));
  iter_shift_unit #(.N(32), .STEP(4)) dut4 (.clk(clk), .resetn(resetn), .bus(bus4));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [2:0]  mode;
    logic [31:0] din;
    logic [4:0]  shamt;
    logic [31:0] exp_dout;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  initial begin
    int lat;
    int busyc;
    logic [31:0] held;

    total = 0;
    passed = 0;
    vecs[0]  = '{3'b001, 32'h0000_0001,  5'd4, 32'h0000_0010, 1'b0, 5};
    vecs[1]  = '{3'b011, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0, 32};
    vecs[2]  = '{3'b010, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b0, 32};
    vecs[3]  = '{3'b101, 32'h0000_0001,  5'd1, 32'h8000_0000, 1'b0, 2};
    vecs[4]  = '{3'b100, 32'h8000_0001,  5'd4, 32'h0000_0018, 1'b0, 5};
    vecs[5]  = '{3'b010, 32'h1234_5678,  5'd0, 32'h1234_5678, 1'b0, 1};
    vecs[6]  = '{3'b111, 32'hA5A5_A5A5,  5'd7, 32'hA5A5_A5A5, 1'b1, 1};
    vecs[7]  = '{3'b000, 32'hDEAD_BEEF,  5'd9, 32'hDEAD_BEEF, 1'b0, 1};
    vecs[8]  = '{3'b110, 32'h0F0F_0F0F,  5'd3, 32'h0F0F_0F0F, 1'b1, 1};
    vecs[9]  = '{3'b011, 32'h7FFF_FFF0,  5'd4, 32'h07FF_FFFF, 1'b0, 5};
    vecs[10] = '{3'b011, 32'hF000_0000,  5'd8, 32'hFFF0_0000, 1'b0, 9};
    vecs[11] = '{3'b100, 32'h1234_5678, 5'd31, 32'h091A_2B3C, 1'b0, 32};
    vecs[12] = '{3'b001, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000, 1'b0, 32};
    vecs[13] = '{3'b101, 32'h0000_000F,  5'd2, 32'hC000_0003, 1'b0, 3};

    resetn = 1'b0;
    bus1.start = 1'b0; bus1.mode = '0; bus1.din = '0; bus1.shamt = '0;
    bus4.start = 1'b0; bus4.mode = '0; bus4.din = '0; bus4.shamt = '0;
`ifdef SHIFT_ABORT_EN
    bus1.abort = 1'b0;
    bus4.abort = 1'b0;
`endif
    #12;
    check("rst busy", {31'b0, bus1.busy}, 32'h0);
    check("rst done", {31'b0, bus1.done}, 32'h0);
    check("rst err",  {31'b0, bus1.err},  32'h0);
    check("rst dout", bus1.dout, 32'h0);
    check("rst dout4", bus4.dout, 32'h0);
    @(negedge clk) resetn = 1'b1;

    // STEP=1 table
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      bus1.start = 1'b1; bus1.mode = vecs[i].mode;
      bus1.din = vecs[i].din; bus1.shamt = vecs[i].shamt;
      @(posedge clk); #1;
      bus1.start = 1'b0; bus1.din = '0; bus1.mode = 3'b000; bus1.shamt = '0;
      lat = 1; busyc = 0;
      while (!bus1.done && lat < 100) begin
        if (bus1.busy) busyc++;
        @(posedge clk); #1;
        lat++;
      end
      check($sformatf("v%0d latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d busy cycles", i), busyc, vecs[i].exp_lat - 1);
      check($sformatf("v%0d dout", i), bus1.dout, vecs[i].exp_dout);
      check($sformatf("v%0d err", i), {31'b0, bus1.err}, {31'b0, vecs[i].exp_err});
      held = bus1.dout;
      @(posedge clk); #1;
      check($sformatf("v%0d done pulse", i), {31'b0, bus1.done}, 32'h0);
      check($sformatf("v%0d dout hold", i), bus1.dout, held);
    end

    // STEP=4: SLL 1 by 9 in steps 4,4,1 with a start pulse during busy
    @(negedge clk);
    bus4.start = 1'b1; bus4.mode = 3'b001; bus4.din = 32'h1; bus4.shamt = 5'd9;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    check("s4 c1 busy", {31'b0, bus4.busy}, 32'h1);
    @(negedge clk);
    bus4.start = 1'b1; bus4.mode = 3'b010; bus4.din = 32'hFFFF_FFFF; bus4.shamt = 5'd3;
    @(posedge clk); #1;
    check("s4 c2 busy", {31'b0, bus4.busy}, 32'h1);
    check("s4 c2 dout", bus4.dout, 32'h0000_0010);
    @(negedge clk) bus4.start = 1'b0;
    @(posedge clk); #1;
    check("s4 c3 busy", {31'b0, bus4.busy}, 32'h1);
    check("s4 c3 dout", bus4.dout, 32'h0000_0100);
    @(posedge clk); #1;
    check("s4 c4 done", {31'b0, bus4.done}, 32'h1);
    check("s4 c4 busy", {31'b0, bus4.busy}, 32'h0);
    check("s4 c4 dout", bus4.dout, 32'h0000_0200);
    check("s4 c4 err",  {31'b0, bus4.err}, 32'h0);

    // back-to-back from DONE: SRA by 6 (steps 4,2)
    @(negedge clk);
    bus4.start = 1'b1; bus4.mode = 3'b011; bus4.din = 32'h8000_0000; bus4.shamt = 5'd6;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    check("b2b no bubble", {31'b0, bus4.busy}, 32'h1);
    @(posedge clk); #1;
    check("b2b mid dout", bus4.dout, 32'hF800_0000);
    @(posedge clk); #1;
    check("b2b done", {31'b0, bus4.done}, 32'h1);
    check("b2b dout", bus4.dout, 32'hFE00_0000);
    // start held in DONE with LOAD: done again on the very next cycle
    @(negedge clk);
    bus4.start = 1'b1; bus4.mode = 3'b000; bus4.din = 32'h0000_0055; bus4.shamt = 5'd0;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    check("b2b load done", {31'b0, bus4.done}, 32'h1);
    check("b2b load dout", bus4.dout, 32'h0000_0055);

    // async reset during SHIFT cycle 2 of a shamt=10 run
    @(negedge clk);
    bus1.start = 1'b1; bus1.mode = 3'b001; bus1.din = 32'h1; bus1.shamt = 5'd10;
    @(posedge clk); #1;
    bus1.start = 1'b0;
    @(posedge clk); #1;
    check("pre-rst busy", {31'b0, bus1.busy}, 32'h1);
    #2 resetn = 1'b0;
    #1;
    check("async rst busy", {31'b0, bus1.busy}, 32'h0);
    check("async rst done", {31'b0, bus1.done}, 32'h0);
    check("async rst dout", bus1.dout, 32'h0);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;
    check("post-rst idle busy", {31'b0, bus1.busy}, 32'h0);
    check("post-rst idle done", {31'b0, bus1.done}, 32'h0);

`ifdef SHIFT_ABORT_EN
    // abort in SHIFT cycle 3 of SLL 1 by 10
    @(negedge clk);
    bus1.start = 1'b1; bus1.mode = 3'b001; bus1.din = 32'h1; bus1.shamt = 5'd10;
    @(posedge clk); #1;
    bus1.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk) bus1.abort = 1'b1;
    @(posedge clk); #1;
    bus1.abort = 1'b0;
    check("abort done", {31'b0, bus1.done}, 32'h1);
    check("abort err",  {31'b0, bus1.err}, 32'h1);
    check("abort dout", bus1.dout, 32'h0000_0008);
    @(posedge clk); #1;
    check("abort idle", {31'b0, bus1.busy | bus1.done}, 32'h0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/iter_shift_unit.md
Name: iter_shift_unit

Overview:
Parametrised multi-cycle shift unit, the successor to the 32-bit universal shift register. It generalises width and step size, takes a variable shift amount and supports arithmetic and rotate modes. Operation uses a start/busy/done handshake with a fixed, computable latency. It serves the datapath as a small-area alternative to a combinational barrel shifter.

Parameters:
N, 32, data width in bits; must be at least 2.
STEP, 1, bit positions shifted per cycle; must be a power of two and no greater than N.
SHW, $clog2(N), width of the shift-amount port; derived, not overridden.

Ports:
clk  input  1  rising-edge clock
resetn  input  1  asynchronous active-low reset
start  input  1  request; accepted only in IDLE or DONE
mode  input  3  operation, sampled at accept
din  input  N  operand, sampled at accept
shamt  input  SHW  shift amount, sampled at accept
busy  output  1  high while in SHIFT
done  output  1  one-cycle pulse when the result is valid
dout  output  N  working/result register
err  output  1  high with done when the sampled mode is reserved

Behaviour:
- Reset (resetn=0, asynchronous): state=IDLE, busy=0, done=0, err=0, dout=0, remaining-count=0. This applies at any time, including mid-operation; the in-flight operation is discarded.
- Modes:
  - 000 LOAD
  - 001 SLL: zero fill
  - 010 SRL: zero fill
  - 011 SRA: MSB replicated
  - 100 ROL
  - 101 ROR
  - 110 and 111: reserved; behave as LOAD and set err=1 on the done cycle.
- FSM has three states: IDLE, SHIFT, DONE.
  - IDLE, start=1: dout<=din; mode latched; cnt<=shamt (LOAD/reserved force cnt<=0). Next state is SHIFT if cnt>0, else DONE.
  - SHIFT: each cycle shifts dout by k=min(STEP,cnt) using the latched mode; cnt<=cnt-k. When cnt-k==0, next state is DONE.
  - DONE: done=1 for exactly this cycle. Next state is IDLE. If start=1 in DONE, the request is accepted exactly as from IDLE (back-to-back; no bubble).
- busy=1 iff state==SHIFT. done and err are registered and are 0 outside DONE.
- Latency from the accepting edge to the done cycle is ceil(shamt/STEP)+1 cycles, in all modes. shamt=0 or LOAD gives 1 cycle, and dout equals din.
- start is ignored while busy. din, shamt and mode may change freely after accept.
- dout shows intermediate values during SHIFT and is valid only when done=1. It then holds the result until the next accept.
- Rotates wrap bits end-to-end. SRA keeps the sign on every step. shamt is at most N-1 by its width; no modulo logic is required.
- Partial last step: when cnt<STEP, exactly cnt positions are shifted.

Optional Feature:
Macro SHIFT_ABORT_EN.
- Defined: adds an input port abort (1 bit). abort=1 in SHIFT forces the next state to DONE. done pulses with err=1, and dout holds the partial value at the abort edge. abort is ignored in IDLE and DONE, and start takes precedence in DONE.
- Undefined: no abort port; an operation always runs to completion.

Test Plan:
1. N=32, STEP=1, SLL din=0x00000001 shamt=4: busy for 4 cycles, done 5 cycles after accept, dout=0x00000010, err=0.
2. SRA din=0x80000000 shamt=31: dout=0xFFFFFFFF, done after 32 cycles. Also SRL with the same operand: dout=0x00000001.
3. ROR din=0x00000001 shamt=1: dout=0x80000000. ROL din=0x80000001 shamt=4: dout=0x00000018.
4. shamt=0 SRL din=0x12345678: done next cycle, dout=0x12345678, busy never high. mode=111 din=0xA5A5A5A5: done next cycle, err=1, dout=0xA5A5A5A5.
5. STEP=4, SLL din=0x1 shamt=9: busy 3 cycles (4,4,1), dout=0x200. A start pulse during busy is ignored. Start held in DONE starts the next operation without an IDLE cycle.
6. resetn=0 asynchronously at SHIFT cycle 2 of a shamt=10 run: outputs clear immediately. With SHIFT_ABORT_EN, abort at SHIFT cycle 3 of SLL 0x1 shamt=10 (STEP=1): done next cycle, err=1, dout=0x8.
